// File: rtl/vga_fb_arbiter.sv
// Purpose: shares one synchronous frame-buffer RAM between the VGA read path and a renderer write port.
// Latency: pixel tick at t -> read issued t+1 -> pix_rgb valid from t+2+MEM_LAT; writes go to the RAM in the handshake cycle.
// Backpressure: display reads take strict priority; wr_ready drops while a read is pending or in flight.
module vga_fb_arbiter #(
  parameter int FB_W    = 320,
  parameter int FB_H    = 240,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 12,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pixel_tick,
  input  logic [9:0]        x_pixel,
  input  logic [9:0]        y_pixel,
  input  logic              DE,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_rgb,
  output logic              rd_overrun
);

  // Number of frame-buffer pixels as an address-width constant for range checks.
  localparam logic [ADDR_W-1:0] FB_N   = ADDR_W'(FB_W * FB_H);
  localparam logic [ADDR_W-1:0] FB_W_A = ADDR_W'(FB_W);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          wait_cnt, wait_cnt_nxt;
  logic                rd_pend;
  logic [ADDR_W-1:0]   rd_addr;
  logic [MEM_LAT:0]    blank_pipe;
  logic                rd_issue;
  logic                rd_done;
  logic                wr_in_range;

  // 2x2 upscale: each buffer pixel covers two display columns and two rows.
  logic [9:0]          x_half;
  logic [9:0]          y_half;
  logic [ADDR_W-1:0]   req_addr;

  assign x_half      = x_pixel >> 1;
  assign y_half      = y_pixel >> 1;
  assign req_addr    = ADDR_W'(y_half) * FB_W_A + ADDR_W'(x_half);
  assign wr_in_range = (wr_addr < FB_N);

  // Arbitration FSM: state and read-latency counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next state and RAM port drive; outputs are zero whenever the port is unused.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    wr_ready     = 1'b0;
    wr_err       = 1'b0;
    rd_issue     = 1'b0;
    rd_done      = 1'b0;
    case (state)
      IDLE: begin
        if (rd_pend) begin
          mem_en       = 1'b1;
          mem_addr     = rd_addr;
          rd_issue     = 1'b1;
          state_nxt    = RD_WAIT;
          wait_cnt_nxt = 2'(MEM_LAT);
        end else if (!reset) begin
          // Reset gates the ready so no write slips through while held in reset.
          wr_ready = 1'b1;
          if (wr_valid) begin
            if (wr_in_range) begin
              mem_en    = 1'b1;
              mem_we    = 1'b1;
              mem_addr  = wr_addr;
              mem_wdata = wr_data;
            end else begin
              // Out-of-range writes are consumed and flagged, never reach the RAM.
              wr_err = 1'b1;
            end
          end
        end
      end
      RD_WAIT: begin
        wait_cnt_nxt = wait_cnt - 2'd1;
        if (wait_cnt == 2'd1) begin
          rd_done   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Display request capture; a newer tick replaces any still-pending request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend <= 1'b0;
      rd_addr <= '0;
    end else begin
      if (pixel_tick) begin
        rd_pend <= DE;
        if (DE) begin
          rd_addr <= req_addr;
        end
      end else if (rd_issue) begin
        rd_pend <= 1'b0;
      end
    end
  end

  // Sticky overrun: a tick found the previous request not yet issued.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_overrun <= 1'b0;
    end else if (pixel_tick && rd_pend) begin
      rd_overrun <= 1'b1;
    end
  end

  // Blank tokens travel a pipe as long as the read path so black lands on the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blank_pipe <= '0;
    end else begin
      blank_pipe <= {blank_pipe[MEM_LAT-1:0], pixel_tick && !DE};
    end
  end

  // Pixel output register: load returning read data, or black for a blank slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_rgb <= '0;
    end else if (rd_done) begin
      pix_rgb <= mem_rdata;
    end else if (blank_pipe[MEM_LAT]) begin
      pix_rgb <= '0;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

  localparam int FB_W    = 320;
  localparam int FB_H    = 240;
  localparam int ADDR_W  = 17;
  localparam int DATA_W  = 12;
  localparam int MEM_LAT = 1;
  localparam int FB_N    = FB_W * FB_H;
  localparam int NRAND   = 800;

  logic              clk;
  logic              reset;
  logic              pixel_tick;
  logic [9:0]        x_pixel;
  logic [9:0]        y_pixel;
  logic              DE;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_err;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] pix_rgb;
  logic              rd_overrun;

  vga_fb_arbiter #(
    .FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT)
  ) dut (
    .clk(clk), .reset(reset), .pixel_tick(pixel_tick), .x_pixel(x_pixel),
    .y_pixel(y_pixel), .DE(DE), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_err(wr_err), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .pix_rgb(pix_rgb), .rd_overrun(rd_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_val(int i);
    return DATA_W'((i * 37 + 11) ^ (i >> 5));
  endfunction

  // Behavioural single-port RAM with one-cycle read latency.
  logic [DATA_W-1:0] ram [0:FB_N-1];
  logic              ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < FB_N; i++) ram[i] <= init_val(i);
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic t, input logic de, input logic [9:0] x, input logic [9:0] y,
                       input logic wv, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd);
    pixel_tick = t; DE = de; x_pixel = x; y_pixel = y;
    wr_valid = wv; wr_addr = wa; wr_data = wd;
  endtask

  typedef struct {
    logic              tick;
    logic              de;
    logic [9:0]        x;
    logic [9:0]        y;
    logic              wv;
    logic [ADDR_W-1:0] wa;
    logic [DATA_W-1:0] wd;
    logic              e_rdy;
    logic              e_en;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
    logic              e_err;
    logic [DATA_W-1:0] e_pix;
  } vec_t;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] val;
  } pe_t;

  vec_t              tbl [13];
  logic [DATA_W-1:0] shadow [0:FB_N-1];
  pe_t               q [$];

  initial begin
    // Directed vectors: write preload, read with write contention, blank, bad write, last pixel.
    tbl[0]  = '{1'b0, 1'b0, 10'd0,   10'd0,   1'b1, 17'd322,   12'hABC, 1'b1, 1'b1, 1'b1, 17'd322,   12'hABC, 1'b0, 12'h000};
    tbl[1]  = '{1'b1, 1'b1, 10'd5,   10'd3,   1'b0, 17'd0,     12'h000, 1'b1, 1'b0, 1'b0, 17'd0,     12'h000, 1'b0, 12'h000};
    tbl[2]  = '{1'b0, 1'b0, 10'd0,   10'd0,   1'b1, 17'd100,   12'h123, 1'b0, 1'b1, 1'b0, 17'd322,   12'h000, 1'b0, 12'h000};
    tbl[3]  = '{1'b0, 1'b0, 10'd0,   10'd0,   1'b1, 17'd100,   12'h123, 1'b0, 1'b0, 1'b0, 17'd0,     12'h000, 1'b0, 12'h000};
    tbl[4]  = '{1'b0, 1'b0, 10'd0,   10'd0,   1'b1, 17'd100,   12'h123, 1'b1, 1'b1, 1'b1, 17'd100,   12'h123, 1'b0, 12'hABC};
    tbl[5]  = '{1'b1, 1'b0, 10'd0,   10'd500, 1'b1, 17'd76800, 12'h555, 1'b1, 1'b0, 1'b0, 17'd0,     12'h000, 1'b1, 12'hABC};
    tbl[6]  = '{1'b0, 1'b0, 10'd0,   10'd0,   1'b0, 17'd0,     12'h000, 1'b1, 1'b0, 1'b0, 17'd0,     12'h000, 1'b0, 12'hABC};
    tbl[7]  = '{1'b0, 1'b0, 10'd0,   10'd0,   1'b0, 17'd0,     12'h000, 1'b1, 1'b0, 1'b0, 17'd0,     12'h000, 1'b0, 12'hABC};
    tbl[8]  = '{1'b0, 1'b0, 10'd0,   10'd0,   1'b1, 17'd76799, 12'h7FF, 1'b1, 1'b1, 1'b1, 17'd76799, 12'h7FF, 1'b0, 12'h000};
    tbl[9]  = '{1'b1, 1'b1, 10'd639, 10'd479, 1'b0, 17'd0,     12'h000, 1'b1, 1'b0, 1'b0, 17'd0,     12'h000, 1'b0, 12'h000};
    tbl[10] = '{1'b0, 1'b0, 10'd0,   10'd0,   1'b0, 17'd0,     12'h000, 1'b0, 1'b1, 1'b0, 17'd76799, 12'h000, 1'b0, 12'h000};
    tbl[11] = '{1'b0, 1'b0, 10'd0,   10'd0,   1'b0, 17'd0,     12'h000, 1'b0, 1'b0, 1'b0, 17'd0,     12'h000, 1'b0, 12'h000};
    tbl[12] = '{1'b0, 1'b0, 10'd0,   10'd0,   1'b0, 17'd0,     12'h000, 1'b1, 1'b0, 1'b0, 17'd0,     12'h000, 1'b0, 12'h7FF};

    for (int i = 0; i < FB_N; i++) shadow[i] = init_val(i);

    // Reset with a write request held: nothing may be accepted or driven.
    reset = 1'b1; ram_init = 1'b1;
    drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 17'd5, 12'h0F0);
    repeat (3) @(negedge clk);
    #1;
    chk("reset wr_ready", 32'(wr_ready), 32'd0);
    chk("reset mem_en", 32'(mem_en), 32'd0);
    chk("reset mem_addr", 32'(mem_addr), 32'd0);
    chk("reset wr_err", 32'(wr_err), 32'd0);
    chk("reset pix_rgb", 32'(pix_rgb), 32'd0);
    chk("reset rd_overrun", 32'(rd_overrun), 32'd0);
    @(negedge clk);
    reset = 1'b0; ram_init = 1'b0;
    drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 17'd0, 12'h0);
    repeat (2) @(negedge clk);

    // Table-driven directed sequence, one row per clock.
    for (int i = 0; i < 13; i++) begin
      if (i > 0) @(negedge clk);
      drive(tbl[i].tick, tbl[i].de, tbl[i].x, tbl[i].y, tbl[i].wv, tbl[i].wa, tbl[i].wd);
      #1;
      chk($sformatf("row%0d wr_ready", i), 32'(wr_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d mem_en", i), 32'(mem_en), 32'(tbl[i].e_en));
      chk($sformatf("row%0d mem_we", i), 32'(mem_we), 32'(tbl[i].e_we));
      chk($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("row%0d mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].e_wdata));
      chk($sformatf("row%0d wr_err", i), 32'(wr_err), 32'(tbl[i].e_err));
      chk($sformatf("row%0d pix_rgb", i), 32'(pix_rgb), 32'(tbl[i].e_pix));
    end
    chk("table rd_overrun", 32'(rd_overrun), 32'd0);

    // Fresh start for the randomized run; the model keeps its own copy of the RAM.
    @(negedge clk);
    drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 17'd0, 12'h0);
    reset = 1'b1; ram_init = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0; ram_init = 1'b0;
    for (int i = 0; i < FB_N; i++) shadow[i] = init_val(i);
    @(negedge clk);

    begin
      logic              hist1, hist2, tk, de, wv, acc, e_we, e_en, e_rdy;
      logic [9:0]        x, y;
      logic [ADDR_W-1:0] wa, h1_addr, e_addr;
      logic [DATA_W-1:0] wd, exp_pix;
      int                raddr, n_acc;
      hist1 = 1'b0; hist2 = 1'b0; wv = 1'b0; wa = '0; wd = '0;
      h1_addr = '0; exp_pix = '0; n_acc = 0;
      for (int c = 0; c < NRAND; c++) begin
        if (c > 0) @(negedge clk);
        tk = ((c % 4) == 0) && (c < NRAND - 8);
        de = ($urandom_range(0, 3) != 0);
        x  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 639)) : 10'($urandom_range(0, 63));
        y  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 479)) : 10'($urandom_range(0, 31));
        if (!wv && $urandom_range(0, 3) != 0) begin
          wv = 1'b1;
          wa = ($urandom_range(0, 7) == 0) ? ADDR_W'(FB_N + $urandom_range(0, 1000))
                                            : ADDR_W'($urandom_range(0, 4999));
          wd = DATA_W'($urandom);
        end
        drive(tk, de, x, y, wv, wa, wd);
        #1;
        while (q.size() > 0 && q[0].due <= c) begin
          exp_pix = q[0].val;
          void'(q.pop_front());
        end
        // A read owns the port on the cycle after its tick and the cycle after that.
        e_rdy  = !(hist1 || hist2);
        acc    = wv && e_rdy;
        e_we   = acc && (int'(wa) < FB_N);
        e_en   = hist1 || e_we;
        e_addr = hist1 ? h1_addr : (e_we ? wa : '0);
        chk($sformatf("rand c%0d wr_ready", c), 32'(wr_ready), 32'(e_rdy));
        chk($sformatf("rand c%0d mem_en", c), 32'(mem_en), 32'(e_en));
        chk($sformatf("rand c%0d mem_we", c), 32'(mem_we), 32'(e_we));
        chk($sformatf("rand c%0d mem_addr", c), 32'(mem_addr), 32'(e_addr));
        chk($sformatf("rand c%0d mem_wdata", c), 32'(mem_wdata), e_we ? 32'(wd) : 32'd0);
        chk($sformatf("rand c%0d wr_err", c), 32'(wr_err), 32'(acc && (int'(wa) >= FB_N)));
        chk($sformatf("rand c%0d pix_rgb", c), 32'(pix_rgb), 32'(exp_pix));
        chk($sformatf("rand c%0d rd_overrun", c), 32'(rd_overrun), 32'd0);
        if (e_we) shadow[wa] = wd;
        if (acc) begin
          wv = 1'b0;
          n_acc++;
        end
        raddr = (int'(y) / 2) * FB_W + int'(x) / 2;
        if (tk) q.push_back('{c + 3, de ? shadow[raddr] : DATA_W'(0)});
        hist2   = hist1;
        hist1   = tk && de;
        h1_addr = ADDR_W'(raddr);
      end
      if (n_acc == 0) chk("rand writes accepted", 32'd0, 32'd1);
    end

    // Back-to-back ticks: overrun must latch, then reset during a read clears everything.
    @(negedge clk);
    drive(1'b1, 1'b1, 10'd2, 10'd2, 1'b0, 17'd0, 12'h0);
    @(negedge clk);
    drive(1'b1, 1'b1, 10'd4, 10'd2, 1'b0, 17'd0, 12'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b1, 17'd9, 12'h999);
    #1;
    chk("ovr set", 32'(rd_overrun), 32'd1);
    chk("ovr rd_wait wr_ready", 32'(wr_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("ovr replaced issue en", 32'(mem_en), 32'd1);
    chk("ovr replaced issue addr", 32'(mem_addr), 32'd322);
    chk("ovr sticky", 32'(rd_overrun), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("mid reset wr_ready", 32'(wr_ready), 32'd0);
    chk("mid reset mem_en", 32'(mem_en), 32'd0);
    chk("mid reset wr_err", 32'(wr_err), 32'd0);
    chk("mid reset pix_rgb", 32'(pix_rgb), 32'd0);
    chk("mid reset rd_overrun", 32'(rd_overrun), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 10'd0, 10'd0, 1'b0, 17'd0, 12'h0);
    #1;
    chk("post reset wr_ready", 32'(wr_ready), 32'd1);
    chk("post reset mem_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    #1;
    chk("post reset mem_en 2", 32'(mem_en), 32'd0);
    chk("post reset pix_rgb", 32'(pix_rgb), 32'd0);
    chk("post reset rd_overrun", 32'(rd_overrun), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Arbitrates a single-port synchronous frame-buffer RAM between two requesters: the VGA display read path and a write requester (the road-graphics renderer).
- Display reads are hard real-time and have strict priority. One read is issued per visible pixel, paced by the 1-in-4 pixel tick. Writes use the remaining memory slots through a valid/ready handshake.
- The frame buffer is QVGA (320x240). Each buffer pixel is upscaled 2x2 onto the 640x480 display.

Parameters:
- FB_W, 320: frame-buffer width in pixels.
- FB_H, 240: frame-buffer height in pixels.
- ADDR_W, 17: memory address width. Must satisfy 2^ADDR_W >= FB_W*FB_H.
- DATA_W, 12: pixel width (RGB444).
- MEM_LAT, 1: RAM read latency in clk cycles, from mem_en to mem_rdata valid. Range 1..2.

Ports:
- clk, in, 1: system clock (100 MHz).
- reset, in, 1: asynchronous, active-high.
- pixel_tick, in, 1: one-clk pulse per pixel. Nominally every 4 clk.
- x_pixel, in, 10: display column. Valid when pixel_tick=1.
- y_pixel, in, 10: display row. Valid when pixel_tick=1.
- DE, in, 1: display-enable. Valid when pixel_tick=1.
- wr_valid, in, 1: write request.
- wr_ready, out, 1: write accepted this cycle when wr_valid && wr_ready.
- wr_addr, in, ADDR_W: linear frame-buffer write address.
- wr_data, in, DATA_W: write pixel.
- wr_err, out, 1: one-cycle pulse when an accepted write is out of range.
- mem_en, out, 1: RAM enable.
- mem_we, out, 1: RAM write enable.
- mem_addr, out, ADDR_W: RAM address.
- mem_wdata, out, DATA_W: RAM write data.
- mem_rdata, in, DATA_W: RAM read data.
- pix_rgb, out, DATA_W: pixel to the display.
- rd_overrun, out, 1: sticky flag; a display request was lost or replaced.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE; rd_pend=0; rd_overrun=0.
- Request capture (cycle t, pixel_tick=1):
  - DE=1: set rd_pend. Register rd_addr = (y_pixel>>1)*FB_W + (x_pixel>>1); for FB_W=320 this is shift-add ((y>>1)<<8)+((y>>1)<<6)+(x>>1).
  - DE=0: no memory request. Push a "blank" token instead.
- FSM states:
  - IDLE:
    - If rd_pend: mem_en=1, mem_we=0, mem_addr=rd_addr. Clear rd_pend. Go to RD_WAIT with wait counter = MEM_LAT.
    - Else if wr_valid: wr_ready=1.
  - RD_WAIT:
    - wr_ready=0 and mem_en=0.
    - Decrement the counter each cycle. On the cycle mem_rdata is valid (MEM_LAT cycles after issue), capture it into pix_rgb and go to IDLE.
- Write issue:
  - wr_ready is combinational: (state==IDLE) && !rd_pend.
  - On handshake with wr_addr < FB_W*FB_H: mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data, all in the same cycle.
  - On handshake with wr_addr >= FB_W*FB_H: the write is accepted and dropped (mem_en=0), and wr_err pulses for 1 cycle.
- Priority: if a read is pending and wr_valid=1 in the same cycle, the read wins and wr_ready=0. The writer must hold wr_valid/wr_addr/wr_data stable until accepted.
- Pixel latency:
  - Tick at t gives read issue at t+1, and pix_rgb updates on the edge ending cycle t+1+MEM_LAT. pix_rgb is visible from t+2+MEM_LAT (t+3 for MEM_LAT=1).
  - A blank token drives pix_rgb to 0 at the identical cycle (delay pipe of 1+MEM_LAT).
  - pix_rgb holds its value between updates.
- Write bandwidth (MEM_LAT=1, tick every 4 clk): 2 write slots per pixel period.
- Overrun:
  - A pixel_tick arriving while rd_pend=1 sets rd_overrun. The new request replaces the pending one.
  - A pixel_tick arriving while in RD_WAIT queues normally and does not set rd_overrun.
  - rd_overrun clears only on reset.
- Reset mid-operation: an in-flight read is abandoned and pix_rgb goes to 0. A pending write is not accepted; no partial write is issued.
- Wrap-around: at the line/frame wrap (x=639→0, y=479→0) there is no special handling, because addressing is purely combinational on x/y.

Test Plan:
- Tick every 4 clk, DE=1, x=5, y=3, RAM preloaded at addr 322 = 0xABC → mem_addr=322 at t+1, pix_rgb=0xABC from t+3.
- Continuous wr_valid with ticks every 4 clk, DE=1 → exactly 2 writes accepted per 4 clk; wr_ready=0 at t+1 and t+2; no read ever delayed.
- wr_valid and rd_pend both set in one cycle → read issued, wr_ready=0; write accepted in the next IDLE cycle with addr and data intact.
- Tick with DE=0, y=500 → no mem_en; pix_rgb=0 at t+3.
- wr_addr=76800 accepted → mem_en=0, wr_err pulses 1 cycle.
- Ticks 1 clk apart → rd_overrun=1 and stays 1; assert reset while in RD_WAIT → all outputs 0 the next cycle and rd_overrun clears.
